// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU. Logic, add/sub and compare/branch ops finish in one cycle.
//           Mul/mulhu/divu/remu run on an iterative radix-2 datapath.
// Latency:  single-cycle ops -> out_valid_o the cycle after accept;
//           mul/div ops -> out_valid_o WIDTH+1 cycles after accept.
// Backpressure: ready_o is low only while iterating (WIDTH cycles). in_valid_i is ignored
//               while ready_o is low. There is no output stall; the result is presented
//               for one out_valid_o cycle and held afterwards.
//
// Ports:
//   clk_i, rst_i              rising-edge clock, synchronous active-high reset
//   in_valid_i, ready_o       request handshake (accept = in_valid_i && ready_o at clk edge)
//   ctrl_i, src1_i, src2_i    opcode and operands, sampled at accept
//   out_valid_o               one-cycle completion pulse
//   result_o, flag_o, zero_o  result, branch condition, result==0 (held until next completion)

module alu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             flag_o,
  output logic             zero_o
);

  // Operation codes
  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SLTU  = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_REMU  = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_BNE   = 4'd9;
  localparam logic [3:0] OP_BGE   = 4'd10;
  localparam logic [3:0] OP_BGT   = 4'd11;
  localparam logic [3:0] OP_NOR   = 4'd12;
  localparam logic [3:0] OP_BEQ   = 4'd13;
  localparam logic [3:0] OP_MULHU = 4'd14;

  // Counter value during the final iteration step.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  // Multiplicand (mul) or divisor (div).
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  // Shared 2*WIDTH accumulator.
  //   mul: {partial product high, multiplier bits still to consume} -> final product
  //   div: {partial remainder, dividend bits still to consume / quotient bits} -> {rem, quo}
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 flag_q, flag_d;
  logic                 zero_q, zero_d;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU on the live inputs (used only at an accept edge)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_res;
  logic             alu_flag;
  logic [WIDTH-1:0] alu_diff;
  logic             alu_slt;
  logic             alu_sltu;

  always_comb begin
    alu_diff = src1_i - src2_i;
    alu_slt  = $signed(src1_i) < $signed(src2_i);
    alu_sltu = src1_i < src2_i;
    alu_res  = '0;
    alu_flag = 1'b0;
    case (ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, alu_sltu};
      OP_SUB:  alu_res = alu_diff;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, alu_slt};
      OP_NOR:  alu_res = ~(src1_i | src2_i);
      OP_BNE: begin
        alu_res  = alu_diff;
        alu_flag = (src1_i != src2_i);
      end
      OP_BGE: begin
        alu_res  = alu_diff;
        alu_flag = !alu_slt;
      end
      OP_BGT: begin
        alu_res  = alu_diff;
        alu_flag = $signed(src1_i) > $signed(src2_i);
      end
      OP_BEQ: begin
        alu_res  = alu_diff;
        alu_flag = (src1_i == src2_i);
      end
      // Iterative ops never take this path; opcode 15 yields zero/no flag.
      default: begin
        alu_res  = '0;
        alu_flag = 1'b0;
      end
    endcase
  end

  logic in_is_multi;
  logic in_is_mul;

  always_comb begin
    in_is_mul   = (ctrl_i == OP_MUL) || (ctrl_i == OP_MULHU);
    in_is_multi = in_is_mul || (ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU);
  end

  // ---------------------------------------------------------------------------
  // One iteration step of the radix-2 multiplier / restoring divider
  // ---------------------------------------------------------------------------
  logic               op_is_mul;
  logic               op_hi_half;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   multi_res;

  always_comb begin
    op_is_mul  = (op_q == OP_MUL) || (op_q == OP_MULHU);
    // MULHU and REMU read the upper half of the accumulator, MUL and DIVU the lower.
    op_hi_half = (op_q == OP_MULHU) || (op_q == OP_REMU);

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right. The carry
    // out of the add becomes the new MSB.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the partial remainder.
    // If it is >= divisor, subtract and record a 1 quotient bit.
    // The partial remainder is always < divisor, so the difference fits in WIDTH bits
    // and the modular low-bit subtract is exact.
    // Divisor 0 always subtracts nothing: quotient all ones, remainder = dividend.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_sub   = div_shift[WIDTH-1:0] - opnd_q;
    div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    step_next = op_is_mul ? mul_next : div_next;
    multi_res = op_hi_half ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath next-state
  // ---------------------------------------------------------------------------
  logic accept;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    flag_d   = flag_q;
    zero_d   = zero_q;
    accept   = in_valid_i && (state_q != BUSY);

    case (state_q)
      IDLE, DONE: begin
        // DONE lasts one cycle; a request in that cycle gives back-to-back operation.
        state_d = IDLE;
        if (accept) begin
          if (in_is_multi) begin
            state_d = BUSY;
            cnt_d   = '0;
            op_d    = ctrl_i;
            opnd_d  = in_is_mul ? src1_i : src2_i;
            acc_d   = {{WIDTH{1'b0}}, (in_is_mul ? src2_i : src1_i)};
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            flag_d   = alu_flag;
            zero_d   = (alu_res == '0);
          end
        end
      end

      BUSY: begin
        acc_d = step_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d  = DONE;
          result_d = multi_res;
          flag_d   = 1'b0;
          zero_d   = (multi_res == '0);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      zero_q   <= zero_d;
    end
  end

  assign ready_o     = (state_q != BUSY);
  assign out_valid_o = (state_q == DONE);
  assign result_o    = result_q;
  assign flag_o      = flag_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed, table-driven bench for alu_iter (WIDTH=32) plus hand-written
// sequences for back-to-back issue and reset in the middle of an iteration.

module tb_alu_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [3:0]   ctrl = 4'd0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         ready_o;
  logic         out_valid_o;
  logic [W-1:0] result_o;
  logic         flag_o;
  logic         zero_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .ctrl_i     (ctrl),
    .src1_i     (src1),
    .src2_i     (src2),
    .ready_o    (ready_o),
    .out_valid_o(out_valid_o),
    .result_o   (result_o),
    .flag_o     (flag_o),
    .zero_o     (zero_o)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         flag;
    logic         zero;
    int           lat;
    int           rdy_low;
  } vec_t;

  vec_t vecs[32];
  int   n_vec = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic flag);
    bit multi;
    multi = (op == 4'd4) || (op == 4'd5) || (op == 4'd8) || (op == 4'd14);
    vecs[n_vec].op      = op;
    vecs[n_vec].a       = a;
    vecs[n_vec].b       = b;
    vecs[n_vec].res     = res;
    vecs[n_vec].flag    = flag;
    vecs[n_vec].zero    = (res == '0);
    vecs[n_vec].lat     = multi ? W + 1 : 1;
    vecs[n_vec].rdy_low = multi ? W : 0;
    n_vec++;
  endtask

  // Issue one request, then watch until out_valid_o (bounded). lat counts
  // negedges after the accept edge; -1 means no completion within the budget.
  // With poke set, a stray request is presented mid-iteration.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, output int lat, output int rdy_low,
                        output logic [W-1:0] res, output logic flg, output logic zr);
    lat = -1;
    rdy_low = 0;
    res = '0;
    flg = 1'b0;
    zr = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    ctrl = op;
    src1 = a;
    src2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ctrl = 4'hF;
    src1 = $urandom;
    src2 = $urandom;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (!ready_o) rdy_low++;
      if (out_valid_o) begin
        lat = i;
        res = result_o;
        flg = flag_o;
        zr = zero_o;
        break;
      end
      if (poke && i == 5) begin
        in_valid = 1'b1;
        ctrl = 4'd2;
        src1 = 32'd1;
        src2 = 32'd1;
      end
      if (poke && i == 6) in_valid = 1'b0;
    end
  endtask

  initial begin
    int lat, rdy_low, pulses;
    logic [W-1:0] res;
    logic flg, zr;

    // Single-cycle ops
    add_vec(4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0); // ADD wraps
    add_vec(4'd0,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0); // AND
    add_vec(4'd1,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0); // OR
    add_vec(4'd12, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b0); // NOR
    add_vec(4'd6,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0); // SUB wraps
    add_vec(4'd6,  32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 1'b0); // SUB equal: no flag
    add_vec(4'd7,  32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0); // SLT -2<1
    add_vec(4'd3,  32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b0); // SLTU
    add_vec(4'd7,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0); // SLT min<max
    add_vec(4'd10, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0); // BGE neg>=0 false
    add_vec(4'd10, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1); // BGE equal
    add_vec(4'd11, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0); // BGT equal
    add_vec(4'd11, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); // BGT max>min
    add_vec(4'd13, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1); // BEQ
    add_vec(4'd9,  32'h0000_1234, 32'h0000_1235, 32'hFFFF_FFFF, 1'b1); // BNE
    add_vec(4'd9,  32'h0000_0042, 32'h0000_0042, 32'h0000_0000, 1'b0); // BNE equal
    add_vec(4'd15, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0); // invalid
    // Iterative ops
    add_vec(4'd8,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0); // MUL
    add_vec(4'd14, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0); // MULHU
    add_vec(4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0); // MUL max*max
    add_vec(4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0); // MULHU max*max
    add_vec(4'd4,  32'd100,       32'd7,         32'd14,        1'b0); // DIVU
    add_vec(4'd5,  32'd100,       32'd7,         32'd2,         1'b0); // REMU
    add_vec(4'd4,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0); // DIVU by 0
    add_vec(4'd5,  32'd5,         32'd0,         32'd5,         1'b0); // REMU by 0
    add_vec(4'd4,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0); // DIVU by 1
    add_vec(4'd5,  32'd7,         32'd10,        32'd7,         1'b0); // REMU a<b

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_out_valid", 32'(out_valid_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_flag", 32'(flag_o), 32'd0);
    check("reset_zero", 32'(zero_o), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < n_vec; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat > 1, lat, rdy_low, res, flg, zr);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_ready_low", i), 32'(rdy_low), 32'(vecs[i].rdy_low));
      check($sformatf("v%0d_result", i), res, vecs[i].res);
      check($sformatf("v%0d_flag", i), 32'(flg), 32'(vecs[i].flag));
      check($sformatf("v%0d_zero", i), 32'(zr), 32'(vecs[i].zero));
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", i), 32'(out_valid_o), 32'd0);
      check($sformatf("v%0d_hold", i), result_o, vecs[i].res);
    end

    // Back-to-back: SLT then SLTU on consecutive edges
    @(negedge clk);
    in_valid = 1'b1;
    ctrl = 4'd7;
    src1 = 32'hFFFF_FFFE;
    src2 = 32'h0000_0001;
    @(posedge clk);
    #1 ctrl = 4'd3;
    @(negedge clk);
    check("b2b_first_valid", 32'(out_valid_o), 32'd1);
    check("b2b_first_ready", 32'(ready_o), 32'd1);
    check("b2b_first_result", result_o, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_valid", 32'(out_valid_o), 32'd1);
    check("b2b_second_result", result_o, 32'd0);
    @(negedge clk);
    check("b2b_end", 32'(out_valid_o), 32'd0);

    // Reset during an iteration, with a request held during reset
    @(negedge clk);
    in_valid = 1'b1;
    ctrl = 4'd8;
    src1 = 32'hFFFF_FFFF;
    src2 = 32'h0000_0002;
    @(posedge clk);
    #1 in_valid = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid_o) pulses++;
    end
    check("rst_busy_ready", 32'(ready_o), 32'd0);
    rst = 1'b1;
    in_valid = 1'b1;
    ctrl = 4'd2;
    src1 = 32'd1;
    src2 = 32'd1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_mid_ready", 32'(ready_o), 32'd1);
    check("rst_mid_result", result_o, 32'd0);
    check("rst_mid_zero", 32'(zero_o), 32'd1);
    check("rst_mid_flag", 32'(flag_o), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid_o) pulses++;
    end
    check("rst_mid_no_valid", 32'(pulses), 32'd0);
    run_op(4'd2, 32'd3, 32'd4, 1'b0, lat, rdy_low, res, flg, zr);
    check("post_rst_add_latency", 32'(lat), 32'd1);
    check("post_rst_add_result", res, 32'd7);
    check("post_rst_add_zero", 32'(zr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, handshaked successor to the pipeline's single-cycle combinational ALU.
- Logic, add/sub and compare/branch-condition ops complete in one cycle.
- Multiply (low and high word) and unsigned divide/remainder run on an iterative radix-2 datapath taking WIDTH cycles.
- Sits in the EX stage; the hazard unit stalls the pipe while ready_o is low.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous active-high reset
in_valid_i  input  1  request valid; accepted on a rising edge where in_valid_i && ready_o
ctrl_i  input  4  operation code, sampled at accept
src1_i  input  WIDTH  operand A, sampled at accept
src2_i  input  WIDTH  operand B, sampled at accept
ready_o  output  1  can accept a request this cycle
out_valid_o  output  1  one-cycle pulse: result_o/flag_o/zero_o valid
result_o  output  WIDTH  operation result
flag_o  output  1  branch condition (ops 9,10,11,13), else 0
zero_o  output  1  result_o == 0

Behaviour:
- Op codes:
  - 0 AND; 1 OR; 2 ADD (wraps mod 2^WIDTH); 3 SLTU (1/0, unsigned); 6 SUB (wraps); 7 SLT (1/0, signed); 12 NOR.
  - 9 BNE: result = A-B, flag = A!=B.
  - 10 BGE: result = A-B, flag = A>=B, signed.
  - 11 BGT: result = A-B, flag = A>B, signed.
  - 13 BEQ: result = A-B, flag = A==B.
  - 8 MUL: low WIDTH bits of A*B, unsigned. 14 MULHU: high WIDTH bits of A*B, unsigned.
  - 4 DIVU: quotient. 5 REMU: remainder.
  - 15: invalid; result 0, flag 0, single-cycle.
- Only ops 9/10/11/13 may set flag_o.
- FSM states IDLE, BUSY, DONE.
  - ready_o = (state != BUSY), so a new request may be accepted in the DONE cycle (back-to-back).
  - Accepting a single-cycle op: next state DONE, and the result is registered at the accept edge.
  - Accepting a mul/div op: next state BUSY, with operands latched and the counter cleared.
  - BUSY: one shift-add (mul) or shift-subtract restoring step (div) per cycle. Counter increments each step. After step WIDTH-1 completes, the result is registered and the state moves to DONE.
  - DONE: out_valid_o = 1 for exactly one cycle. Next state is IDLE, or BUSY/DONE if a new request is accepted that edge.
- Latency, accept edge to out_valid_o:
  - Single-cycle ops: out_valid_o high in the cycle immediately after the accept edge.
  - Mul/div ops: out_valid_o high WIDTH+1 cycles after the accept edge; ready_o is low for WIDTH cycles.
- No output backpressure; the consumer must take the result during the out_valid_o cycle.
- result_o, flag_o and zero_o hold their last values until the next completion.
- in_valid_i while ready_o=0 is ignored: no queuing, no error.
- Divide by zero (B=0): quotient all ones, remainder = A; still takes WIDTH+1 cycles.
- Multiplier datapath: 2*WIDTH-bit product register. The low half is used for MUL, the high half for MULHU. Operands are never sign-extended.
- Reset (rst_i=1 at a rising edge):
  - state IDLE, counter 0.
  - out_valid_o 0, result_o 0, flag_o 0, zero_o 1. ready_o = 1 once reset deasserts.
  - Reset mid-BUSY aborts the operation and produces no out_valid_o.
  - A request presented while rst_i=1 is not accepted.
- Operand inputs may change freely after the accept edge; the block uses only latched copies.

Test Plan:
- Reset, then ADD A=0xFFFFFFFF B=0x00000001 -> out_valid_o 1 cycle later, result 0x00000000, zero_o=1, flag_o=0.
- SLT A=0xFFFFFFFE(-2) B=0x00000001 -> result 1; SLTU same operands -> result 0. Issue back-to-back in consecutive cycles -> two consecutive out_valid_o pulses.
- BGE A=0x80000000 B=0x00000000 -> flag_o=0, result 0x80000000. BEQ A=B=0x1234 -> flag_o=1, zero_o=1.
- MUL and MULHU, A=0xFFFFFFFF B=0x00000002 -> ready_o low 32 cycles, out_valid_o at cycle 33. MUL result 0xFFFFFFFE, MULHU result 0x00000001. in_valid_i pulsed mid-BUSY is ignored.
- DIVU A=100 B=7 -> result 14; REMU -> result 2. DIVU A=5 B=0 -> 0xFFFFFFFF; REMU A=5 B=0 -> 5. All complete at cycle 33.
- Start MUL, assert rst_i at BUSY cycle 10 -> no out_valid_o, ready_o=1 and result_o=0 after reset. A following ADD 3+4 -> result 7 next cycle.
